// File: rtl/cmp_stream.sv
// Qualified comparator: a relation between a and b must hold for THRESH consecutive
// valid samples before match asserts; entries into MATCH set sticky and bump hit_cnt.
module cmp_stream #(
    parameter int WIDTH  = 5,
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             cond,
    output logic             match,
    output logic             sticky,
    output logic [CNT_W-1:0] hit_cnt
);
    localparam int SW = $clog2(THRESH + 1);
    localparam logic [SW:0]      THRESH_V = (SW + 1)'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        MATCH = 2'd2
    } state_t;

    state_t           state_reg;
    logic [SW-1:0]    streak_reg;
    logic             cond_reg;
    logic             match_reg;
    logic             sticky_reg;
    logic [CNT_W-1:0] hit_cnt_reg;

    logic             rel;
    logic [SW:0]      streak_inc;
    logic             entry;

    always_comb begin
        rel = 1'b0;
        case (mode)
            2'b00:   rel = (a == b);
            2'b01:   rel = (a != b);
            2'b10:   rel = (a < b);
            default: rel = (a > b);
        endcase
    end

    // An entry is the sample that completes the streak from outside MATCH.
    assign streak_inc = {1'b0, streak_reg} + (SW + 1)'(1);
    assign entry      = in_valid && rel && (state_reg != MATCH) && (streak_inc == THRESH_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            streak_reg  <= '0;
            cond_reg    <= 1'b0;
            match_reg   <= 1'b0;
            sticky_reg  <= 1'b0;
            hit_cnt_reg <= '0;
        end else begin
            if (in_valid) begin
                cond_reg <= rel;
                case (state_reg)
                    IDLE, ARM: begin
                        if (rel) begin
                            streak_reg <= streak_inc[SW-1:0];
                            if (entry) begin
                                state_reg <= MATCH;
                                match_reg <= 1'b1;
                            end else begin
                                state_reg <= ARM;
                            end
                        end else begin
                            state_reg  <= IDLE;
                            streak_reg <= '0;
                        end
                    end
                    MATCH: begin
                        if (!rel) begin
                            state_reg  <= IDLE;
                            streak_reg <= '0;
                            match_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg  <= IDLE;
                        streak_reg <= '0;
                        match_reg  <= 1'b0;
                    end
                endcase
            end

            // Set wins over clear when an entry and clr coincide.
            if (entry) begin
                sticky_reg <= 1'b1;
                if (clr)
                    hit_cnt_reg <= CNT_W'(1);
                else if (hit_cnt_reg != CNT_MAX)
                    hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
            end else if (clr) begin
                sticky_reg  <= 1'b0;
                hit_cnt_reg <= '0;
            end
        end
    end

    assign cond    = cond_reg;
    assign match   = match_reg;
    assign sticky  = sticky_reg;
    assign hit_cnt = hit_cnt_reg;
endmodule

// File: tb/tb_cmp_stream.sv
// Bench for cmp_stream: three parameterisations share one stimulus stream and are
// compared every cycle against a streak-counting reference model.
module tb_cmp_stream;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] a = '0;
    logic [4:0] b = '0;
    logic [1:0] mode = '0;
    logic       clr = 1'b0;

    logic       cond0, match0, sticky0;
    logic [7:0] hit0;
    logic       cond1, match1, sticky1;
    logic [1:0] hit1;
    logic       cond2, match2, sticky2;
    logic [1:0] hit2;

    int checks = 0;
    int errors = 0;
    int txn = 0;

    // Model state per instance: 0 = (T4,C8), 1 = (T4,C2), 2 = (T1,C2)
    int m_thresh [3] = '{4, 4, 1};
    int m_cmax   [3] = '{255, 3, 3};
    int m_streak [3];
    int m_cond   [3];
    int m_sticky [3];
    int m_cnt    [3];

    always #5 clk = ~clk;

    cmp_stream #(.WIDTH(5), .THRESH(4), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .clr(clr),
        .cond(cond0), .match(match0), .sticky(sticky0), .hit_cnt(hit0));
    cmp_stream #(.WIDTH(5), .THRESH(4), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .clr(clr),
        .cond(cond1), .match(match1), .sticky(sticky1), .hit_cnt(hit1));
    cmp_stream #(.WIDTH(5), .THRESH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .mode(mode), .clr(clr),
        .cond(cond2), .match(match2), .sticky(sticky2), .hit_cnt(hit2));

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, obs, exp, txn);
        end
    endtask

    function automatic int relation(input int x, input int y, input int m);
        case (m)
            0:       return (x == y) ? 1 : 0;
            1:       return (x != y) ? 1 : 0;
            2:       return (x < y) ? 1 : 0;
            default: return (x > y) ? 1 : 0;
        endcase
    endfunction

    task automatic model_update(input bit r, input bit v, input int x, input int y,
                                input int m, input bit c);
        for (int i = 0; i < 3; i++) begin
            bit entered;
            entered = 1'b0;
            if (r) begin
                m_streak[i] = 0; m_cond[i] = 0; m_sticky[i] = 0; m_cnt[i] = 0;
            end else begin
                if (v) begin
                    m_cond[i] = relation(x, y, m);
                    if (m_cond[i] == 1) begin
                        entered = (m_streak[i] < m_thresh[i]) && (m_streak[i] + 1 >= m_thresh[i]);
                        m_streak[i] = (m_streak[i] + 1 > m_thresh[i]) ? m_thresh[i] : m_streak[i] + 1;
                    end else begin
                        m_streak[i] = 0;
                    end
                end
                if (entered) begin
                    m_sticky[i] = 1;
                    if (c) m_cnt[i] = 1;
                    else if (m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
                end else if (c) begin
                    m_sticky[i] = 0;
                    m_cnt[i] = 0;
                end
            end
        end
    endtask

    function automatic int m_match(input int i);
        return (m_streak[i] == m_thresh[i]) ? 1 : 0;
    endfunction

    task automatic compare_all();
        check("u0_cond", cond0, m_cond[0]);   check("u0_match", match0, m_match(0));
        check("u0_sticky", sticky0, m_sticky[0]); check("u0_hit", hit0, m_cnt[0]);
        check("u1_cond", cond1, m_cond[1]);   check("u1_match", match1, m_match(1));
        check("u1_sticky", sticky1, m_sticky[1]); check("u1_hit", hit1, m_cnt[1]);
        check("u2_cond", cond2, m_cond[2]);   check("u2_match", match2, m_match(2));
        check("u2_sticky", sticky2, m_sticky[2]); check("u2_hit", hit2, m_cnt[2]);
    endtask

    task automatic step(input bit r, input bit v, input int x, input int y,
                        input int m, input bit c);
        rst = r; in_valid = v; a = 5'(x); b = 5'(y); mode = 2'(m); clr = c;
        model_update(r, v, x, y, m, c);
        @(posedge clk);
        #1;
        txn++;
        compare_all();
        $display("txn %0d rst=%0b v=%0b a=%0d b=%0d mode=%0d clr=%0b | match=%0b%0b%0b hit=%0d,%0d,%0d",
                 txn, r, v, x, y, m, c, match0, match1, match2, hit0, hit1, hit2);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_streak[i] = 0; m_cond[i] = 0; m_sticky[i] = 0; m_cnt[i] = 0;
        end
        @(posedge clk);
        #1;

        // Reset held two cycles with a true sample present
        step(1, 1, 3, 3, 0, 0);
        step(1, 1, 3, 3, 0, 0);
        check("rst_cond", cond0, 0);
        check("rst_match", match0, 0);
        check("rst_hit", hit0, 0);
        step(0, 1, 3, 3, 0, 0);
        check("post_rst_cond", cond0, 1);
        check("post_rst_match", match0, 0);

        // Qualification over four consecutive true samples
        step(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 5, 5, 0, 0);
            check("qual_match", match0, (k == 4) ? 1 : 0);
        end
        check("qual_sticky", sticky0, 1);
        check("qual_hit", hit0, 1);
        step(0, 1, 5, 5, 0, 0);
        check("qual_hold_hit", hit0, 1);

        // Break, then a streak interrupted by idle cycles
        step(0, 1, 5, 6, 0, 0);
        check("break_cond", cond0, 0);
        check("break_match", match0, 0);
        check("break_sticky", sticky0, 1);
        step(0, 1, 5, 5, 0, 0);
        step(0, 1, 5, 5, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 2, 0, 0);
        step(0, 1, 5, 5, 0, 0);
        check("gap_match3", match0, 0);
        step(0, 1, 5, 5, 0, 0);
        check("gap_match4", match0, 1);
        check("gap_hit", hit0, 2);
        step(0, 1, 5, 6, 0, 0);

        // Modes, including an unsigned boundary
        step(0, 1, 3, 9, 2, 0); check("mode_lt", cond0, 1);
        step(0, 1, 3, 9, 3, 0); check("mode_gt", cond0, 0);
        step(0, 1, 3, 9, 1, 0); check("mode_ne", cond0, 1);
        step(0, 1, 3, 9, 0, 0); check("mode_eq", cond0, 0);
        step(0, 1, 31, 0, 3, 0); check("mode_gt_unsigned", cond0, 1);

        // Saturation of a 2-bit counter over five entries
        step(1, 0, 0, 0, 0, 0);
        for (int e = 1; e <= 5; e++) begin
            for (int k = 0; k < 4; k++) step(0, 1, 7, 7, 0, 0);
            check("sat_hit", hit1, (e < 3) ? e : 3);
            step(0, 1, 7, 8, 0, 0);
        end
        step(0, 0, 0, 0, 0, 1);
        check("clr_hit", hit1, 0);
        check("clr_sticky", sticky1, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 7, 7, 0, 0);
        step(0, 1, 7, 7, 0, 1);
        check("clr_entry_hit", hit1, 1);
        check("clr_entry_sticky", sticky1, 1);

        // THRESH=1 and reset while in MATCH
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 9, 9, 0, 0);
        check("t1_match", match2, 1);
        check("t1_hit", hit2, 1);
        step(1, 1, 9, 9, 0, 0);
        check("t1_rst_match", match2, 0);
        check("t1_rst_hit", hit2, 0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            int x, y;
            x = $urandom_range(0, 31);
            y = ($urandom_range(0, 1) == 1) ? x : $urandom_range(0, 31);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), x, y,
                 ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 0,
                 ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
